// File: rtl/ahb_bus_matrix_pkg.sv
// ============================================================================
// Module : ahb_bus_matrix_pkg
// Brief  : Shared AHB encodings and types for the bus matrix input stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ahb_bus_matrix_pkg;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    localparam logic [2:0] BRS_SINGLE = 3'b000;
    localparam logic [2:0] BRS_INCR   = 3'b001;
    localparam logic [2:0] BRS_WRAP4  = 3'b010;
    localparam logic [2:0] BRS_INCR4  = 3'b011;
    localparam logic [2:0] BRS_WRAP8  = 3'b100;
    localparam logic [2:0] BRS_INCR8  = 3'b101;
    localparam logic [2:0] BRS_WRAP16 = 3'b110;
    localparam logic [2:0] BRS_INCR16 = 3'b111;

    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_bus_matrix_input_hold_if.sv
// ============================================================================
// Module : ahb_bus_matrix_input_hold_if
// Brief  : Master-port and output-stage signal bundle of the input hold stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ahb_bus_matrix_input_hold_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int PROT_WIDTH = 4
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [PROT_WIDTH-1:0] HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  active_trans;
    logic                  HREADYMUXS;
    logic                  HRESPMUXS;

    logic                  sel_trans;
    logic [ADDR_WIDTH-1:0] HADDRM;
    logic [1:0]            HTRANSM;
    logic                  HWRITEM;
    logic [2:0]            HSIZEM;
    logic [2:0]            HBURSTM;
    logic [PROT_WIDTH-1:0] HPROTM;
    logic                  HMASTLOCKM;
    logic                  HREADYOUTS;
    logic                  HRESPS;

    // The input stage is the slave of its master port
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_trans, HREADYMUXS, HRESPMUXS,
        output sel_trans, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
               HMASTLOCKM, HREADYOUTS, HRESPS
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
               HMASTLOCKS, HREADYS, active_trans, HREADYMUXS, HRESPMUXS,
        input  sel_trans, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
               HMASTLOCKM, HREADYOUTS, HRESPS
    );
endinterface

`default_nettype wire

// File: rtl/ahb_bus_matrix_input_hold.sv
// ============================================================================
// Module : ahb_bus_matrix_input_hold
// Brief  : Per-master AHB input stage; passes or holds the address phase.
//          Optional macro AHB_INPUT_HOLD_LOCK_IDLE_EN: locked IDLE requests.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_bus_matrix_input_hold
    import ahb_bus_matrix_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PROT_WIDTH = 4
) (
    input  wire                          HCLK,
    input  wire                          HRESETn,
    ahb_bus_matrix_input_hold_if.slave   bus
);

    hold_state_t           state;
    hold_state_t           state_nxt;
    logic                  pend;
    logic                  new_trans;
    logic                  accept;
    logic                  capture;
    logic                  data_phase;

    logic [ADDR_WIDTH-1:0] held_addr;
    logic [1:0]            held_trans;
    logic                  held_write;
    logic [2:0]            held_size;
    logic [2:0]            held_burst;
    logic [PROT_WIDTH-1:0] held_prot;
    logic                  held_lock;

`ifdef AHB_INPUT_HOLD_LOCK_IDLE_EN
    // Locked IDLE beats keep the arbiter request alive through a lock sequence
    assign new_trans = bus.HSELS & bus.HREADYS &
                       (bus.HTRANSS[1] | (bus.HMASTLOCKS & (bus.HTRANSS == TRN_IDLE)));
`else
    assign new_trans = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
`endif

    assign pend    = (state == ST_HELD);
    assign accept  = bus.active_trans & bus.HREADYMUXS & (pend | new_trans);
    assign capture = (state == ST_IDLE) & new_trans & ~bus.active_trans;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (new_trans & ~bus.active_trans)     state_nxt = ST_HELD;
            ST_HELD: if (bus.active_trans & bus.HREADYMUXS) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_addr  <= '0;
            held_trans <= TRN_IDLE;
            held_write <= 1'b0;
            held_size  <= '0;
            held_burst <= BRS_SINGLE;
            held_prot  <= '0;
            held_lock  <= 1'b0;
        end else if (capture) begin
            held_addr  <= bus.HADDRS;
            held_trans <= bus.HTRANSS;
            held_write <= bus.HWRITES;
            held_size  <= bus.HSIZES;
            held_burst <= bus.HBURSTS;
            held_prot  <= bus.HPROTS;
            held_lock  <= bus.HMASTLOCKS;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_phase <= 1'b0;
        end else if (accept) begin
            data_phase <= 1'b1;
        end else if (bus.HREADYMUXS) begin
            data_phase <= 1'b0;
        end
    end

    assign bus.sel_trans  = pend | new_trans;
    assign bus.HADDRM     = pend ? held_addr  : bus.HADDRS;
    assign bus.HTRANSM    = pend ? held_trans : (new_trans ? bus.HTRANSS : TRN_IDLE);
    assign bus.HWRITEM    = pend ? held_write : bus.HWRITES;
    assign bus.HSIZEM     = pend ? held_size  : bus.HSIZES;
    assign bus.HBURSTM    = pend ? held_burst : bus.HBURSTS;
    assign bus.HPROTM     = pend ? held_prot  : bus.HPROTS;
    assign bus.HMASTLOCKM = pend ? held_lock  : bus.HMASTLOCKS;

    assign bus.HREADYOUTS = data_phase ? bus.HREADYMUXS : ~pend;
    assign bus.HRESPS     = data_phase ? bus.HRESPMUXS  : RSP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_ahb_bus_matrix_input_hold.sv
// ============================================================================
// Module : tb_ahb_bus_matrix_input_hold
// Brief  : Directed self-checking bench for the AHB input hold stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_bus_matrix_input_hold;
    import ahb_bus_matrix_pkg::*;

    logic HCLK;
    logic HRESETn;
    int   passed;
    int   total;

    ahb_bus_matrix_input_hold_if #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) bus ();

    ahb_bus_matrix_input_hold #(.ADDR_WIDTH(32), .PROT_WIDTH(4)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                         input logic wr, input logic act, input logic rdy_mux, input logic rsp_mux);
        bus.HSELS        = sel;
        bus.HTRANSS      = trans;
        bus.HADDRS       = addr;
        bus.HWRITES      = wr;
        bus.active_trans = act;
        bus.HREADYMUXS   = rdy_mux;
        bus.HRESPMUXS    = rsp_mux;
    endtask

    initial begin
        logic exp_lock_sel;
        passed = 0;
        total  = 0;
        HRESETn         = 1'b0;
        bus.HSIZES      = 3'b010;
        bus.HBURSTS     = BRS_SINGLE;
        bus.HPROTS      = 4'h3;
        bus.HMASTLOCKS  = 1'b0;
        bus.HREADYS     = 1'b1;
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        chk("reset_readyout", bus.HREADYOUTS, 1);
        chk("reset_resp",     bus.HRESPS,     0);
        chk("reset_sel",      bus.sel_trans,  0);
        chk("reset_htrans",   bus.HTRANSM,    TRN_IDLE);

        next_cycle();
        HRESETn = 1'b1;

        // Pass-through with a free slave path
        next_cycle();
        drive(1'b1, TRN_NONSEQ, 32'h2000_0040, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("pass_addr",     bus.HADDRM,     32'h2000_0040);
        chk("pass_htrans",   bus.HTRANSM,    TRN_NONSEQ);
        chk("pass_sel",      bus.sel_trans,  1);
        chk("pass_readyout", bus.HREADYOUTS, 1);

        next_cycle();
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("pass_dp_readyout", bus.HREADYOUTS, 1);
        chk("pass_no_hold_sel", bus.sel_trans,  0);
        chk("idle_htrans",      bus.HTRANSM,    TRN_IDLE);

        // Held transfer: slave path busy for three cycles
        next_cycle();
        drive(1'b1, TRN_NONSEQ, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("hold_h0_readyout", bus.HREADYOUTS, 1);
        chk("hold_h0_sel",      bus.sel_trans,  1);

        next_cycle();
        drive(1'b1, TRN_SEQ, 32'h5000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("hold_h1_readyout", bus.HREADYOUTS, 0);
        chk("hold_h1_addr",     bus.HADDRM,     32'h4000_0000);
        chk("hold_h1_htrans",   bus.HTRANSM,    TRN_NONSEQ);
        chk("hold_h1_write",    bus.HWRITEM,    1);
        chk("hold_h1_sel",      bus.sel_trans,  1);

        next_cycle();
        drive(1'b1, TRN_SEQ, 32'h5000_0004, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("hold_h2_readyout", bus.HREADYOUTS, 0);
        chk("hold_h2_addr",     bus.HADDRM,     32'h4000_0000);

        next_cycle();
        drive(1'b1, TRN_SEQ, 32'h5000_0008, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("hold_h3_readyout", bus.HREADYOUTS, 0);
        chk("hold_h3_addr",     bus.HADDRM,     32'h4000_0000);
        chk("hold_h3_write",    bus.HWRITEM,    1);

        // Data phase of the released transfer stretches two cycles
        next_cycle();
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wait_w0_readyout", bus.HREADYOUTS, 0);
        chk("wait_w0_resp",     bus.HRESPS,     0);
        chk("hold_released",    bus.sel_trans,  0);

        next_cycle();
        #1;
        chk("wait_w1_readyout", bus.HREADYOUTS, 0);

        next_cycle();
        bus.HREADYMUXS = 1'b1;
        #1;
        chk("wait_w2_readyout", bus.HREADYOUTS, 1);
        chk("wait_w2_resp",     bus.HRESPS,     0);

        // Two-cycle ERROR response
        next_cycle();
        drive(1'b1, TRN_NONSEQ, 32'h6000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("err_addr_readyout", bus.HREADYOUTS, 1);

        next_cycle();
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("err_c1_resp",     bus.HRESPS,     RSP_ERROR);
        chk("err_c1_readyout", bus.HREADYOUTS, 0);

        next_cycle();
        bus.HREADYMUXS = 1'b1;
        #1;
        chk("err_c2_resp",     bus.HRESPS,     RSP_ERROR);
        chk("err_c2_readyout", bus.HREADYOUTS, 1);

        next_cycle();
        bus.HRESPMUXS = 1'b0;
        #1;
        chk("err_done_resp", bus.HRESPS, RSP_OKAY);

        // Reset asserted while a transfer is held
        next_cycle();
        drive(1'b1, TRN_NONSEQ, 32'h7000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        next_cycle();
        #1;
        chk("rst_pre_readyout", bus.HREADYOUTS, 0);
        chk("rst_pre_addr",     bus.HADDRM,     32'h7000_0000);
        HRESETn     = 1'b0;
        bus.HREADYS = 1'b0;
        #1;
        chk("rst_mid_sel",      bus.sel_trans,  0);
        chk("rst_mid_readyout", bus.HREADYOUTS, 1);
        chk("rst_mid_htrans",   bus.HTRANSM,    TRN_IDLE);

        next_cycle();
        HRESETn     = 1'b1;
        bus.HREADYS = 1'b1;
        drive(1'b0, TRN_IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Locked IDLE beat
        next_cycle();
        bus.HMASTLOCKS = 1'b1;
        drive(1'b1, TRN_IDLE, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef AHB_INPUT_HOLD_LOCK_IDLE_EN
        exp_lock_sel = 1'b1;
`else
        exp_lock_sel = 1'b0;
`endif
        #1;
        chk("lock_idle_sel",  bus.sel_trans,  exp_lock_sel);
        chk("lock_idle_lock", bus.HMASTLOCKM, 1);

        next_cycle();
        bus.HMASTLOCKS = 1'b0;
        drive(1'b1, TRN_IDLE, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("unlocked_idle_sel", bus.sel_trans, 0);

        next_cycle();
        drive(1'b0, TRN_NONSEQ, 32'h9000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("unselected_sel",    bus.sel_trans, 0);
        chk("unselected_htrans", bus.HTRANSM,   TRN_IDLE);

        next_cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_bus_matrix_input_hold.md
Name: ahb_bus_matrix_input_hold

Overview:
- Per-master input stage of the AHB bus matrix. It sits directly upstream of the per-slave output arbiters and muxes.
- Samples each address phase from one master port and either passes it straight through or holds it in a register while the target output port is busy.
- Drives the master's HREADYOUT low while a transfer is held, and produces the req_portN request that the arbiters consume.

Parameters:
- ADDR_WIDTH, 32, width of HADDRS and of the held address register.
- PROT_WIDTH, 4, width of HPROTS.

Ports:
- HCLK  input  1  AHB system clock
- HRESETn  input  1  AHB reset, asynchronous, active-low
- HSELS  input  1  port select from master-side decoder
- HADDRS  input  ADDR_WIDTH  address
- HTRANSS  input  2  transfer type
- HWRITES  input  1  write flag
- HSIZES  input  3  transfer size
- HBURSTS  input  3  burst type
- HPROTS  input  PROT_WIDTH  protection
- HMASTLOCKS  input  1  locked transfer
- HREADYS  input  1  master-side bus HREADY
- active_trans  input  1  an output stage is presenting this port's address phase this cycle
- HREADYMUXS  input  1  HREADY returned from the owning output stage
- HRESPMUXS  input  1  HRESP returned from the owning output stage
- sel_trans  output  1  request to the arbiters (req_portN)
- HADDRM  output  ADDR_WIDTH  address presented to the output stages
- HTRANSM  output  2  transfer type presented to the output stages
- HWRITEM  output  1  write flag presented to the output stages
- HSIZEM  output  3  size presented to the output stages
- HBURSTM  output  3  burst presented to the output stages
- HPROTM  output  PROT_WIDTH  protection presented to the output stages
- HMASTLOCKM  output  1  lock presented to the output stages
- HREADYOUTS  output  1  ready to the master
- HRESPS  output  1  response to the master

Behaviour:
- Reset values: pend=0, data_phase=0, all held regs=0. Resulting outputs: HREADYOUTS=1, HRESPS=0 (OKAY), sel_trans=0.
- new_trans = HSELS & HTRANSS[1] & HREADYS.
- Two-state FSM on pend.
  - IDLE → HELD on new_trans & ~active_trans, posedge HCLK. All address signals are latched, and HTRANS is stored as NONSEQ or SEQ as received.
  - HELD → IDLE on active_trans & HREADYMUXS.
  - In HELD, new master inputs are ignored; the master is stalled so they must be stable.
- A new transfer that arrives in the same cycle HELD is released is impossible, because the master is stalled in HELD.
- Output mux: pend ? held regs : live inputs. When not pend and not new_trans, HTRANSM is forced to IDLE (2'b00).
- sel_trans = pend | new_trans. It is combinational, so the arbiter sees the request in the same cycle.
- data_phase register:
  - Set on the cycle after an address phase is accepted, i.e. active_trans & HREADYMUXS with (pend | new_trans).
  - Cleared when HREADYMUXS=1 with no new acceptance.
- HREADYOUTS:
  - data_phase=1 → HREADYMUXS.
  - Otherwise pend=1 → 0.
  - Otherwise → 1.
- HRESPS = data_phase ? HRESPMUXS : 0.
- Two-cycle ERROR:
  - Cycle 1 (HREADYMUXS=0, HRESPMUXS=1): a held transfer, if any, is kept.
  - Cycle 2: if the master drives IDLE, the held transfer is not cancelled, because it was captured before the error. The master sees it complete normally.
- Reset asserted mid-hold: pend and data_phase clear immediately (async). Outputs return to reset values with no glitch requirement beyond that.
- Zero added latency when the slave path is free. Exactly one extra wait cycle minimum when a transfer is held.

Optional Feature:
- Macro: AHB_INPUT_HOLD_LOCK_IDLE_EN.
- Defined: an IDLE transfer with HMASTLOCKS=1 and HSELS=1 is treated as new_trans for the request, so sel_trans stays high. This keeps the arbiter's HMASTLOCKM path asserted across IDLE beats of a locked sequence. It is held like a normal transfer if active_trans=0.
- Undefined: IDLE transfers never request or hold, regardless of HMASTLOCKS.

Decomposition:
- Shared package ahb_bus_matrix_pkg holds:
  - the HTRANS encodings (TRN_IDLE/BUSY/NONSEQ/SEQ);
  - the HBURST encodings;
  - the HRESP encodings RSP_OKAY and RSP_ERROR.
- No sub-module; the hold register bank and FSM are small and stay in one module.

Test Plan:
- Pass-through: HSELS=1, NONSEQ to 0x2000_0040, active_trans=1, HREADYMUXS=1 → same-cycle HADDRM=0x2000_0040, sel_trans=1, HREADYOUTS=1, no hold.
- Held transfer: NONSEQ write to 0x4000_0000 with active_trans=0 for 3 cycles, then 1 → HREADYOUTS=0 for 3 cycles; HADDRM stays 0x4000_0000 while master inputs change; pend clears on the accept cycle.
- Data-phase wait: accepted transfer, then HREADYMUXS=0 for 2 cycles → HREADYOUTS mirrors 0,0,1; HRESPS=0.
- Error response: HRESPMUXS=1 for 2 cycles with HREADYMUXS 0 then 1 → HRESPS=1,1; HREADYOUTS 0,1.
- Reset mid-hold: assert HRESETn=0 while pend=1 → sel_trans=0, HREADYOUTS=1, HTRANSM=IDLE asynchronously.
- Locked IDLE (AHB_INPUT_HOLD_LOCK_IDLE_EN on/off): IDLE with HMASTLOCKS=1 → sel_trans=1 when defined, 0 when undefined.
